sm4_key_sched_ctrl: RTL and testbench
=====================================

# sm4_key_sched_ctrl

Controller that shares the SM4 key-expansion engine between NUM_REQ requesters (host channels loading user keys). It arbitrates round-robin, sequences the engine's enable/valid/finished handshake, and guards the round-key bank against reloads while the cipher core is mid-block. It reports which requester's key and direction currently occupy the round keys. It sits between the channel front-ends and the key-expansion engine; its ke_* outputs drive the engine directly.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT, 40, max WAIT cycles for ke_finished_in before error
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid_in  in  NUM_REQ  per-requester load request, held until ack
- req_key_in  in  NUM_REQ*128  user keys; requester i at [128*i+127:128*i], stable while valid
- req_dec_in  in  NUM_REQ  1 = decryption key order
- req_ack_out  out  NUM_REQ  one-cycle completion pulse to granted requester
- req_err_out  out  1  qualifies req_ack_out: 1 = load failed
- cipher_busy_in  in  1  cipher core is consuming round keys
- ke_sm4_enable_out  out  1  engine global enable
- ke_enable_out  out  1  engine key-expansion enable
- ke_key_out  out  128  user key to engine
- ke_key_valid_out  out  1  key-valid to engine (one-cycle rising edge)
- ke_encdec_out  out  1  direction to engine
- ke_finished_in  in  1  engine done flag (level, cleared by ke_enable_out low)
- keys_valid_out  out  1  round keys are complete and coherent
- owner_id_out  out  clog2(NUM_REQ)  requester owning the loaded keys
- owner_dec_out  out  1  direction of the loaded keys

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE, ABORT.
- IDLE: if any req_valid_in and cipher_busy_in=0, grant the first requester at or after rr_ptr; latch index, key, and dec; set rr_ptr = grant+1 (mod NUM_REQ); go to ISSUE. With cache hit (see Configuration), go to RELEASE without touching the engine; hits are served even when cipher_busy_in=1.
- ISSUE (1 cycle): ke_enable_out=1, ke_key_valid_out=1, keys_valid_out←0; go to WAIT with timer cleared.
- WAIT: ke_enable_out=1, ke_key_valid_out=0; timer increments. ke_finished_in=1 → RELEASE. Timer==TIMEOUT−1 without finished → ABORT.
- RELEASE (1 cycle): ke_enable_out=0 (clears engine flag); req_ack_out[grant]=1, req_err_out=0; keys_valid_out←1; owner_id_out and owner_dec_out←latched values; go to IDLE.
- ABORT (1 cycle): ke_sm4_enable_out=0, ke_enable_out=0; req_ack_out[grant]=1, req_err_out=1; keys_valid_out stays 0; cache invalidated; go to IDLE.
- ke_key_out and ke_encdec_out are registered and stable from ISSUE through RELEASE/ABORT.
- ke_sm4_enable_out=1 in all states except ABORT.
- Reset values: state IDLE, rr_ptr 0, all ack/err/valid outputs 0, ke_sm4_enable_out 0 during reset and 1 from the first cycle after, ke_key_out 0, owner_id_out 0, owner_dec_out 0, keys_valid_out 0.

## Timing
- Miss: grant edge T → ISSUE at T+1 → WAIT from T+2. Ack is asserted the cycle after ke_finished_in is first sampled high.
- Hit: grant at T → ack at T+1.
- Back-to-back grants are spaced by at least one IDLE cycle after RELEASE/ABORT. That cycle guarantees ke_key_valid_out was low the cycle before each ISSUE, which the engine's edge detect requires.
- ke_finished_in high in the same cycle the timer expires: finished wins (RELEASE).
- req_valid_in dropped mid-load: load completes, keys and owner update, and ack is still pulsed.
- cipher_busy_in rising during WAIT is ignored; busy is sampled only at grant.
- Reset asserted mid-operation: all state returns to reset values immediately, with no ack.

## Configuration
- SM4_KEY_CACHE_EN defined: in IDLE, a request whose key equals the stored last-good key, whose dec equals owner_dec_out, and with keys_valid_out=1 is a hit. Hits are served without engine activity and transfer ownership to the requester. Stored key registers (128 b) are present.
- Not defined: every grant takes the ISSUE path; no key store; cipher_busy_in blocks all grants.

## Structure
- Package sm4_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RELEASE, ABORT);
  - SM4_KEY_W=128 and SM4_RK_W=32;
  - the default TIMEOUT constant.
- Sub-module sm4_rr_arbiter (NUM_REQ) is natural. It is combinational grant-from-pointer; the pointer update stays in the controller.

## Test plan
- Single load: req0 key 0123456789abcdeffedcba9876543210, dec=0; engine model finishes 33 cycles after ISSUE → ack[0] one cycle later, err=0, keys_valid=1, owner_id=0.
- Contention: req0 and req1 asserted together from reset → req0 served first, then req1. Owner ends at 1, and ISSUE cycles are separated by at least one IDLE cycle.
- Busy gating: cipher_busy_in=1 with req1 pending for 10 cycles → no ISSUE; busy drops → ISSUE within 2 cycles.
- Timeout: engine never raises finished → ABORT after 40 WAIT cycles. ack+err pulse, ke_sm4_enable_out low for one cycle, keys_valid=0.
- Cache hit (SM4_KEY_CACHE_EN): reload the same key and dec from req1 → ack at T+1 with no ke_key_valid_out pulse and owner_id=1. Same key with dec=1 → full ISSUE path.
- Reset asserted in WAIT → all outputs at reset values next cycle; a new request after release completes normally.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 key-schedule controller.
package sm4_pkg;

    localparam int unsigned SM4_KEY_W       = 128;
    localparam int unsigned SM4_RK_W        = 32;
    localparam int unsigned SM4_TIMEOUT_DEF = 40;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StRelease,
        StAbort
    } ks_state_e;

endpackage

// File: rtl/sm4_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after ptr_i.
module sm4_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        // Scan from the farthest offset down so the nearest hit wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// Arbitrates SM4 key-expansion engine access between requesters and tracks round-key ownership.
// Optional last-good-key cache enabled by defining SM4_KEY_CACHE_EN.
module sm4_key_sched_ctrl
    import sm4_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = SM4_TIMEOUT_DEF,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*SM4_KEY_W-1:0]   req_key_in,
    input  logic [NUM_REQ-1:0]             req_dec_in,
    output logic [NUM_REQ-1:0]             req_ack_out,
    output logic                           req_err_out,
    input  logic                           cipher_busy_in,
    output logic                           ke_sm4_enable_out,
    output logic                           ke_enable_out,
    output logic [SM4_KEY_W-1:0]           ke_key_out,
    output logic                           ke_key_valid_out,
    output logic                           ke_encdec_out,
    input  logic                           ke_finished_in,
    output logic                           keys_valid_out,
    output logic [IDX_W-1:0]               owner_id_out,
    output logic                           owner_dec_out
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    ks_state_e             state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      grant_q;
    logic [SM4_KEY_W-1:0]  key_q;
    logic                  dec_q;
    logic                  keys_valid_q;
    logic [IDX_W-1:0]      owner_id_q;
    logic                  owner_dec_q;
    logic [TMR_W-1:0]      timer_q;
    logic                  sm4_en_q;

    logic [NUM_REQ-1:0]    hit_vec;
    logic [NUM_REQ-1:0]    elig;
    logic                  gnt_valid;
    logic [IDX_W-1:0]      gnt_idx;
    logic [SM4_KEY_W-1:0]  sel_key;
    logic                  sel_hit;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

`ifdef SM4_KEY_CACHE_EN
    logic [SM4_KEY_W-1:0]  cache_key_q;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit_vec[i] = req_valid_in[i] && keys_valid_q &&
                         (req_key_in[SM4_KEY_W*i +: SM4_KEY_W] == cache_key_q) &&
                         (req_dec_in[i] == owner_dec_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_key_q <= '0;
        end else if (state_q == StRelease) begin
            cache_key_q <= key_q;
        end
    end
`else
    assign hit_vec = '0;
`endif

    // Busy cipher core only blocks grants that would rewrite the round keys.
    assign elig = cipher_busy_in ? hit_vec : req_valid_in;

    sm4_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (elig),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign sel_key = req_key_in[SM4_KEY_W*int'(gnt_idx) +: SM4_KEY_W];
    assign sel_hit = hit_vec[gnt_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    state_d = sel_hit ? StRelease : StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (ke_finished_in) begin
                    state_d = StRelease;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = StAbort;
                end
            end
            StRelease: state_d = StIdle;
            StAbort:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ack_out       = '0;
        req_err_out       = 1'b0;
        ke_enable_out     = 1'b0;
        ke_key_valid_out  = 1'b0;
        ke_sm4_enable_out = sm4_en_q;
        case (state_q)
            StIssue: begin
                ke_enable_out    = 1'b1;
                ke_key_valid_out = 1'b1;
            end
            StWait: begin
                ke_enable_out = 1'b1;
            end
            StRelease: begin
                req_ack_out[grant_q] = 1'b1;
            end
            StAbort: begin
                req_ack_out[grant_q] = 1'b1;
                req_err_out          = 1'b1;
                ke_sm4_enable_out    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            key_q        <= '0;
            dec_q        <= 1'b0;
            keys_valid_q <= 1'b0;
            owner_id_q   <= '0;
            owner_dec_q  <= 1'b0;
            timer_q      <= '0;
            sm4_en_q     <= 1'b0;
        end else begin
            sm4_en_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        grant_q  <= gnt_idx;
                        key_q    <= sel_key;
                        dec_q    <= req_dec_in[gnt_idx];
                        rr_ptr_q <= rr_next(gnt_idx);
                    end
                end
                StIssue: begin
                    keys_valid_q <= 1'b0;
                    timer_q      <= '0;
                end
                StWait: begin
                    timer_q <= timer_q + 1'b1;
                end
                StRelease: begin
                    keys_valid_q <= 1'b1;
                    owner_id_q   <= grant_q;
                    owner_dec_q  <= dec_q;
                end
                default: ;
            endcase
        end
    end

    assign ke_key_out     = key_q;
    assign ke_encdec_out  = dec_q;
    assign keys_valid_out = keys_valid_q;
    assign owner_id_out   = owner_id_q;
    assign owner_dec_out  = owner_dec_q;

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Scoreboard bench for sm4_key_sched_ctrl with a behavioural key-expansion engine.
module tb_sm4_key_sched_ctrl;
    import sm4_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 40;
    localparam int ENG_LAT = 33;
`ifdef SM4_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic                     clk;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_valid_in;
    logic [NUM_REQ*128-1:0]   req_key_in;
    logic [NUM_REQ-1:0]       req_dec_in;
    logic [NUM_REQ-1:0]       req_ack_out;
    logic                     req_err_out;
    logic                     cipher_busy_in;
    logic                     ke_sm4_enable_out;
    logic                     ke_enable_out;
    logic [127:0]             ke_key_out;
    logic                     ke_key_valid_out;
    logic                     ke_encdec_out;
    logic                     ke_finished_in;
    logic                     keys_valid_out;
    logic [0:0]               owner_id_out;
    logic                     owner_dec_out;

    sm4_key_sched_ctrl #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid_in      (req_valid_in),
        .req_key_in        (req_key_in),
        .req_dec_in        (req_dec_in),
        .req_ack_out       (req_ack_out),
        .req_err_out       (req_err_out),
        .cipher_busy_in    (cipher_busy_in),
        .ke_sm4_enable_out (ke_sm4_enable_out),
        .ke_enable_out     (ke_enable_out),
        .ke_key_out        (ke_key_out),
        .ke_key_valid_out  (ke_key_valid_out),
        .ke_encdec_out     (ke_encdec_out),
        .ke_finished_in    (ke_finished_in),
        .keys_valid_out    (keys_valid_out),
        .owner_id_out      (owner_id_out),
        .owner_dec_out     (owner_dec_out)
    );

    typedef struct {
        int idx;
        bit err;
        bit hit;
        bit dec;
        int req_cyc;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        bit           dec;
    } iss_t;

    exp_t exp_q[$];
    iss_t iss_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   hang = 1'b0;
    bit   post_pend = 1'b0;
    exp_t post_e;
    int   issue_cyc = 0;
    int   last_done = -100;
    bit   prev_kv = 1'b0;
    int   eng_cnt;
    bit   eng_run;

    function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: finished rises ENG_LAT cycles after the key-valid cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ke_finished_in <= 1'b0;
            eng_cnt        <= 0;
            eng_run        <= 1'b0;
        end else if (!ke_enable_out) begin
            ke_finished_in <= 1'b0;
            eng_run        <= 1'b0;
        end else if (ke_key_valid_out) begin
            eng_run <= 1'b1;
            eng_cnt <= 1;
        end else if (eng_run) begin
            eng_cnt <= eng_cnt + 1;
            if (!hang && eng_cnt == ENG_LAT - 1) ke_finished_in <= 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT issues to the engine or acks.
    initial begin
        exp_t e;
        iss_t s;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                iss_q.delete();
                post_pend = 1'b0;
                prev_kv   = 1'b0;
                continue;
            end
            if (post_pend) begin
                post_pend = 1'b0;
                check("keys_valid_after_ack", keys_valid_out, !post_e.err);
                if (!post_e.err) begin
                    check("owner_id", owner_id_out, post_e.idx);
                    check("owner_dec", owner_dec_out, post_e.dec);
                end
            end
            if (ke_key_valid_out) begin
                if (iss_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_issue: key_valid got 1 required 0");
                end else begin
                    s = iss_q.pop_front();
                    check("issue_key", ke_key_out, s.key);
                    check("issue_dec", ke_encdec_out, s.dec);
                    check("issue_prev_kv_low", prev_kv, 0);
                    check("issue_gap_ge2", (cyc - last_done) >= 2, 1);
                end
                issue_cyc = cyc;
            end
            if (req_ack_out != '0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: ack got %0h required 0", req_ack_out);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_vector", req_ack_out, 1 << e.idx);
                    check("ack_err", req_err_out, e.err);
                    if (e.err) begin
                        check("abort_sm4_enable", ke_sm4_enable_out, 0);
                        check("abort_latency", cyc - issue_cyc, TIMEOUT + 1);
                    end else begin
                        check("release_sm4_enable", ke_sm4_enable_out, 1);
                        if (e.hit) check("hit_latency", cyc - e.req_cyc, 1);
                        else       check("miss_latency", cyc - issue_cyc, ENG_LAT + 1);
                    end
                    post_e    = e;
                    post_pend = 1'b1;
                end
                last_done = cyc;
            end
            prev_kv = ke_key_valid_out;
        end
    end

    task automatic start_req(input int idx, input logic [127:0] key, input bit dec,
                             input bit hit, input bit err);
        exp_t e;
        iss_t s;
        req_key_in[128*idx +: 128] = key;
        req_dec_in[idx]            = dec;
        req_valid_in[idx]          = 1'b1;
        e = '{idx: idx, err: err, hit: hit, dec: dec, req_cyc: cyc};
        exp_q.push_back(e);
        if (!hit) begin
            s = '{key: key, dec: dec};
            iss_q.push_back(s);
        end
    endtask

    task automatic wait_ack(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ack_out[idx] && n < 300);
        check($sformatf("ack_seen_req%0d", idx), req_ack_out[idx], 1);
        @(posedge clk);
        #1 req_valid_in[idx] = 1'b0;
    endtask

    task automatic load(input int idx, input logic [127:0] key, input bit dec,
                        input bit hit, input bit err);
        @(posedge clk);
        #1 start_req(idx, key, dec, hit, err);
        wait_ack(idx);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int n;
        reset_n        = 1'b0;
        req_valid_in   = '0;
        req_key_in     = '0;
        req_dec_in     = '0;
        cipher_busy_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", req_ack_out, 0);
        check("rst_err", req_err_out, 0);
        check("rst_keys_valid", keys_valid_out, 0);
        check("rst_owner_id", owner_id_out, 0);
        check("rst_key_out", ke_key_out, 0);
        check("rst_sm4_enable", ke_sm4_enable_out, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("sm4_enable_after_rst", ke_sm4_enable_out, 1);

        load(0, 128'h0123456789abcdeffedcba9876543210, 1'b0, 1'b0, 1'b0);

        // Contention from a fresh reset: req0 first, then req1.
        pulse_reset();
        @(posedge clk);
        #1;
        start_req(0, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0, 1'b0);
        start_req(1, 128'hffeeddccbbaa99887766554433221100, 1'b0, 1'b0, 1'b0);
        fork
            wait_ack(0);
            wait_ack(1);
        join
        @(negedge clk);
        check("contention_owner_final", owner_id_out, 1);

        // Busy gating: no issue while cipher core busy.
        @(posedge clk);
        #1 cipher_busy_in = 1'b1;
        req_key_in[127:0] = 128'h0f0e0d0c0b0a09080706050403020100;
        req_dec_in[0]     = 1'b0;
        req_valid_in[0]   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("busy_no_issue", ke_key_valid_out, 0);
        end
        @(posedge clk);
        #1 cipher_busy_in = 1'b0;
        req_valid_in[0] = 1'b0;
        start_req(0, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ke_key_valid_out && n < 2);
        check("busy_release_issue_2cyc", ke_key_valid_out, 1);
        wait_ack(0);

        // Same key/dec from req1: hit with cache, full load otherwise.
        load(1, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0, CACHE, 1'b0);
        load(1, 128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 1'b0, 1'b0);

        // Timeout.
        hang = 1'b1;
        load(0, 128'hdeadbeefcafebabe0123456789abcdef, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("sm4_enable_after_abort", ke_sm4_enable_out, 1);

        // Reset while waiting on the engine.
        @(posedge clk);
        #1 start_req(1, 128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check("pre_reset_in_wait", ke_enable_out, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        req_valid_in = '0;
        @(negedge clk);
        check("midrst_ack", req_ack_out, 0);
        check("midrst_enable", ke_enable_out, 0);
        check("midrst_sm4_enable", ke_sm4_enable_out, 0);
        check("midrst_keys_valid", keys_valid_out, 0);
        check("midrst_owner_id", owner_id_out, 0);
        check("midrst_owner_dec", owner_dec_out, 0);
        check("midrst_key_out", ke_key_out, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        hang = 1'b0;
        load(1, 128'h13579bdf02468ace13579bdf02468ace, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        check("exp_q_drained", exp_q.size(), 0);
        check("iss_q_drained", iss_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
